cci_mpf_csr_event_counters: RTL

- Downstream consumer of the MPF shim event wires: VTP 4KB/2MB hit/miss, PT-walk busy, failed translation, VC-map mapping changed.
- Registers each single-cycle event pulse and sums it into a per-event counter.
- Exposes the counters to the MPF CSR manager through a one-cycle-latency read port, with per-counter and global clear.
- Sits between the shims' event outputs and the MMIO read path of the CSR manager.

---
 rtl/cci_mpf_csr_event_counters_pkg.sv | 15 +
 rtl/cci_mpf_csr_event_counters_if.sv | 12 +
 rtl/cci_mpf_csr_event_counters_ctr.sv | 27 ++
 rtl/cci_mpf_csr_event_counters.sv | 44 ++++
 4 files changed

// File: rtl/cci_mpf_csr_event_counters_pkg.sv
// cci_mpf_csrs_pkg: event counter indices, counter count and counter type
package cci_mpf_csrs_pkg;
  typedef enum logic [2:0] {
    VTP_4KB_HIT            = 3'd0,
    VTP_4KB_MISS           = 3'd1,
    VTP_2MB_HIT            = 3'd2,
    VTP_2MB_MISS           = 3'd3,
    VTP_PT_WALK_BUSY       = 3'd4,
    VTP_FAILED_TRANSLATION = 3'd5,
    VC_MAP_MAPPING_CHANGED = 3'd6
  } t_cci_mpf_csr_event_idx;
  localparam int CCI_MPF_CSR_N_EVENTS = 7;
  localparam int CCI_MPF_CSR_CTR_WIDTH = 48;
  typedef logic [CCI_MPF_CSR_CTR_WIDTH-1:0] t_cci_mpf_csr_event_ctr;
endpackage

// File: rtl/cci_mpf_csr_event_counters_if.sv
// cci_mpf_csr_event_counters_if: CSR manager read/clear port of the event counters
interface cci_mpf_csr_event_counters_if;
  logic        rd_req;
  logic [7:0]  rd_idx;
  logic        rd_rsp_valid;
  logic [63:0] rd_rsp_data;
  logic        clr_req;
  logic [7:0]  clr_idx;
  logic        clr_all;
  modport master (output rd_req, rd_idx, clr_req, clr_idx, clr_all, input rd_rsp_valid, rd_rsp_data);
  modport slave (input rd_req, rd_idx, clr_req, clr_idx, clr_all, output rd_rsp_valid, rd_rsp_data);
endinterface

// File: rtl/cci_mpf_csr_event_counters_ctr.sv
// cci_mpf_event_counter: one event counter with clear, saturate/wrap and sticky overflow
module cci_mpf_event_counter #(
  parameter int CTR_WIDTH = 48,
  parameter bit SATURATE = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 inc,
  input  logic                 clr,
  output logic [CTR_WIDTH-1:0] ctr,
  output logic                 ovf
);
  logic at_max;
  assign at_max = &ctr;
  // A clear keeps the increment landing in the same cycle so no event is lost
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      ctr <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      ctr <= CTR_WIDTH'(inc);
      ovf <= 1'b0;
    end else if (inc) begin
      ctr <= (at_max && SATURATE) ? ctr : ctr + CTR_WIDTH'(1);
      ovf <= ovf | at_max;
    end
endmodule

// File: rtl/cci_mpf_csr_event_counters.sv
// cci_mpf_csr_event_counters: stages MPF event pulses into counters read/cleared by the CSR manager
module cci_mpf_csr_event_counters
  import cci_mpf_csrs_pkg::*;
#(
  parameter int N_EVENTS = CCI_MPF_CSR_N_EVENTS,
  parameter int CTR_WIDTH = CCI_MPF_CSR_CTR_WIDTH,
  parameter bit SATURATE = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [N_EVENTS-1:0]   evt_in,
  cci_mpf_csr_event_counters_if.slave csr,
  output logic [N_EVENTS-1:0]   ovf
);
  logic [N_EVENTS-1:0]  evt_q;
  logic [CTR_WIDTH-1:0] ctr [N_EVENTS];
  logic [63:0]          rd_val;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) evt_q <= '0;
    else evt_q <= evt_in;
  for (genvar i = 0; i < N_EVENTS; i++) begin : g_ctr
    cci_mpf_event_counter #(.CTR_WIDTH(CTR_WIDTH), .SATURATE(SATURATE)) u_ctr (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (evt_q[i]),
      .clr     (csr.clr_req && (csr.clr_all || csr.clr_idx == 8'(i))),
      .ctr     (ctr[i]),
      .ovf     (ovf[i])
    );
  end
  // Out-of-range indices fall through to zero
  always_comb begin
    rd_val = '0;
    for (int j = 0; j < N_EVENTS; j++) rd_val = (csr.rd_idx == 8'(j)) ? 64'(ctr[j]) : rd_val;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      csr.rd_rsp_valid <= 1'b0;
      csr.rd_rsp_data  <= '0;
    end else begin
      csr.rd_rsp_valid <= csr.rd_req;
      if (csr.rd_req) csr.rd_rsp_data <= rd_val;
    end
endmodule
